// File: rtl/gui_pkg.sv
// Shared types and constants for the screen multiplexer: state encoding,
// pixel/channel widths and the brightness scaling helper.
package gui_pkg;

  typedef enum logic [1:0] {
    MENU     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2,
    GAME     = 2'd3
  } screen_state_t;

  localparam int RGB_W   = 12;
  localparam int CH_W    = 4;
  localparam int LEVEL_W = 5;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 5'd16;

  // Level 16 is identity and level 0 is black; the product never exceeds 240.
  function automatic logic [CH_W-1:0] scale_channel(input logic [CH_W-1:0] ch,
                                                    input logic [LEVEL_W-1:0] level);
    logic [8:0] product;
    product = {5'b0, ch} * {4'b0, level};
    return CH_W'(product >> 4);
  endfunction

endpackage

// File: rtl/fade_scaler.sv
// Combinational per-channel brightness scaler for one 4:4:4 pixel.
// Collapses to a plain wire when SCREEN_FADE_EN is not defined.
module fade_scaler
  import gui_pkg::*;
(
  input  logic [RGB_W-1:0]   rgb,
  input  logic [LEVEL_W-1:0] level,
  output logic [RGB_W-1:0]   rgb_scaled
);

`ifdef SCREEN_FADE_EN
  assign rgb_scaled = {scale_channel(rgb[11:8], level),
                       scale_channel(rgb[7:4],  level),
                       scale_channel(rgb[3:0],  level)};
`else
  logic unused_level;
  assign unused_level = ^level;
  assign rgb_scaled   = rgb;
`endif

endmodule

// File: rtl/screen_mux.sv
// Selects between menu and map pixels with a frame-synchronous screen switch.
// Define SCREEN_FADE_EN for a fade-through-black transition; otherwise it is a hard cut.
module screen_mux
  import gui_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [RGB_W-1:0]  rgb_map_in,
  input  logic [RGB_W-1:0]  rgb_menu_in,
  input  logic              start_in,
  input  logic              esc_in,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [RGB_W-1:0]  rgb_out,
  output logic              game_active_out
);

  localparam logic [3:0] STEP_LAST = 4'(FRAMES_PER_STEP - 1);

  screen_state_t        state, state_nxt;
  logic                 vblnk_prev, start_prev, esc_prev;
  logic                 frame_tick, start_edge, esc_edge;
  logic                 src_is_map;
  logic [LEVEL_W-1:0]   level_cur;
  logic [RGB_W-1:0]     rgb_src, rgb_scaled;
  logic                 unused_cfg;

  // Pixel position is carried along by the pipeline but not needed for the mux.
  assign unused_cfg = ^{hcount_in, vcount_in, STEP_LAST};

  assign frame_tick = vblnk_in & ~vblnk_prev;
  assign start_edge = start_in & ~start_prev;
  assign esc_edge   = esc_in   & ~esc_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      start_prev <= 1'b0;
      esc_prev   <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      start_prev <= start_in;
      esc_prev   <= esc_in;
    end
  end

`ifdef SCREEN_FADE_EN
  logic                 dest, dest_nxt;
  logic [LEVEL_W-1:0]   level, level_nxt;
  logic [3:0]           step_cnt, step_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MENU;
      dest     <= 1'b0;
      level    <= LEVEL_MAX;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      dest     <= dest_nxt;
      level    <= level_nxt;
      step_cnt <= step_nxt;
    end
  end

  // Edges are only honoured in the steady states; during a fade they are dropped.
  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    level_nxt = level;
    step_nxt  = step_cnt;
    case (state)
      MENU: begin
        if (start_edge) begin
          state_nxt = FADE_OUT;
          dest_nxt  = 1'b1;
        end
      end
      GAME: begin
        if (esc_edge) begin
          state_nxt = FADE_OUT;
          dest_nxt  = 1'b0;
        end
      end
      FADE_OUT: begin
        if (frame_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (level != '0) level_nxt = level - 5'd1;
            if (level_nxt == '0) state_nxt = FADE_IN;
          end else begin
            step_nxt = step_cnt + 4'd1;
          end
        end
      end
      FADE_IN: begin
        if (frame_tick) begin
          if (step_cnt == STEP_LAST) begin
            step_nxt = '0;
            if (level != LEVEL_MAX) level_nxt = level + 5'd1;
            if (level_nxt == LEVEL_MAX) state_nxt = dest ? GAME : MENU;
          end else begin
            step_nxt = step_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = MENU;
    endcase
  end

  assign level_cur  = level;
  assign src_is_map = (state == GAME) ||
                      ((state == FADE_OUT) && !dest) ||
                      ((state == FADE_IN)  &&  dest);
`else
  logic pending, pending_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MENU;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  // An accepted edge only arms the switch; the cut itself waits for the next frame.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    case (state)
      MENU: begin
        if (frame_tick && pending) begin
          state_nxt   = GAME;
          pending_nxt = 1'b0;
        end else if (start_edge) begin
          pending_nxt = 1'b1;
        end
      end
      GAME: begin
        if (frame_tick && pending) begin
          state_nxt   = MENU;
          pending_nxt = 1'b0;
        end else if (esc_edge) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = MENU;
    endcase
  end

  assign level_cur  = LEVEL_MAX;
  assign src_is_map = (state == GAME);
`endif

  assign rgb_src = src_is_map ? rgb_map_in : rgb_menu_in;

  fade_scaler u_fade_scaler (
    .rgb        (rgb_src),
    .level      (level_cur),
    .rgb_scaled (rgb_scaled)
  );

  // Blanking is taken from the same input cycle as the pixel it masks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      rgb_out         <= '0;
      game_active_out <= 1'b0;
    end else begin
      hsync_out       <= hsync_in;
      vsync_out       <= vsync_in;
      rgb_out         <= (hblnk_in || vblnk_in) ? '0 : rgb_scaled;
      game_active_out <= (state_nxt == GAME);
    end
  end

endmodule

// File: tb/tb_screen_mux.sv
// Randomized bench for screen_mux: a frame-count reference model predicts every output
// each cycle; directed phases cover held keys, ignored presses and reset mid-fade.
module tb_screen_mux;

  localparam int FPS       = 1;
  localparam int FRAME_LEN = 24;
  localparam int VBLNK_LEN = 4;
  localparam int LINE_LEN  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hblnk_in, vblnk_in, hsync_in, vsync_in;
  logic [11:0] rgb_map_in, rgb_menu_in;
  logic        start_in, esc_in;
  logic        hsync_out, vsync_out, game_active_out;
  logic [11:0] rgb_out;

  int check_count = 0;
  int fail_count  = 0;
  int frame_pos   = 0;
  int start_mode  = 0;
  int esc_mode    = 0;

  always #5 clk = ~clk;

  screen_mux #(.FRAMES_PER_STEP(FPS)) dut (
    .clk             (clk),
    .rst             (rst),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .hblnk_in        (hblnk_in),
    .vblnk_in        (vblnk_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .rgb_map_in      (rgb_map_in),
    .rgb_menu_in     (rgb_menu_in),
    .start_in        (start_in),
    .esc_in          (esc_in),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .rgb_out         (rgb_out),
    .game_active_out (game_active_out)
  );

  // Reference model: screen shown is derived from how many frames have passed since the press.
  logic [11:0] exp_rgb;
  logic        exp_hs, exp_vs, exp_game;
  int          m_mode;
  bit          m_fading, m_dest, m_pend;
  int          m_ticks;
  bit          m_prev_vb, m_prev_st, m_prev_esc;

  function automatic logic [3:0] scale_ch(input logic [3:0] c, input int lvl);
    return 4'((int'(c) * lvl) / 16);
  endfunction

  always @(posedge clk or posedge rst) begin : ref_model
    bit          tick, se, ee, use_map;
    int          lvl;
    logic [11:0] px;
    if (rst) begin
      m_mode = 0; m_fading = 0; m_dest = 0; m_pend = 0; m_ticks = 0;
      m_prev_vb = 0; m_prev_st = 0; m_prev_esc = 0;
      exp_rgb = '0; exp_hs = 0; exp_vs = 0; exp_game = 0;
    end else begin
      tick = vblnk_in && !m_prev_vb;
      se   = start_in && !m_prev_st;
      ee   = esc_in && !m_prev_esc;
`ifdef SCREEN_FADE_EN
      if (!m_fading) begin
        lvl = 16; use_map = (m_mode == 1);
      end else if (m_ticks < 16 * FPS) begin
        lvl = 16 - m_ticks / FPS; use_map = !m_dest;
      end else begin
        lvl = (m_ticks - 16 * FPS) / FPS; use_map = m_dest;
      end
`else
      lvl = 16; use_map = (m_mode == 1);
`endif
      px      = use_map ? rgb_map_in : rgb_menu_in;
      exp_rgb = (hblnk_in || vblnk_in) ? 12'h000 :
                {scale_ch(px[11:8], lvl), scale_ch(px[7:4], lvl), scale_ch(px[3:0], lvl)};
      exp_hs  = hsync_in;
      exp_vs  = vsync_in;
`ifdef SCREEN_FADE_EN
      if (m_fading) begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == 32 * FPS) begin
            m_fading = 0;
            m_mode   = m_dest ? 1 : 0;
          end
        end
      end else if (m_mode == 0 && se) begin
        m_fading = 1; m_ticks = 0; m_dest = 1;
      end else if (m_mode == 1 && ee) begin
        m_fading = 1; m_ticks = 0; m_dest = 0;
      end
`else
      if (m_pend && tick) begin
        m_mode = 1 - m_mode;
        m_pend = 0;
      end else if ((m_mode == 0 && se) || (m_mode == 1 && ee)) begin
        m_pend = 1;
      end
`endif
      exp_game   = (m_mode == 1) && !m_fading;
      m_prev_vb  = vblnk_in;
      m_prev_st  = start_in;
      m_prev_esc = esc_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [11:0] actual,
                             input logic [11:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic key_level(input int mode);
    case (mode)
      1:       return 1'b1;
      2:       return ($urandom_range(0, 15) == 0);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic applyStimulus();
    frame_pos   = (frame_pos + 1) % FRAME_LEN;
    vblnk_in    = (frame_pos >= FRAME_LEN - VBLNK_LEN);
    hblnk_in    = ((frame_pos % LINE_LEN) == LINE_LEN - 1);
    hcount_in   = 11'(frame_pos % LINE_LEN);
    vcount_in   = 10'(frame_pos / LINE_LEN);
    hsync_in    = 1'($urandom_range(0, 1));
    vsync_in    = 1'($urandom_range(0, 1));
    rgb_map_in  = ($urandom_range(0, 3) == 0) ? 12'hF00 : 12'($urandom);
    rgb_menu_in = ($urandom_range(0, 3) == 0) ? 12'h0F0 : 12'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      rgb_map_in  = 12'hFFF;
      rgb_menu_in = 12'hFFF;
    end
    start_in = key_level(start_mode);
    esc_in   = key_level(esc_mode);
    if (start_mode == 3) start_mode = 0;
    if (esc_mode == 3) esc_mode = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput("rgb_out", rgb_out, exp_rgb);
      checkOutput("hsync_out", {11'b0, hsync_out}, {11'b0, exp_hs});
      checkOutput("vsync_out", {11'b0, vsync_out}, {11'b0, exp_vs});
      checkOutput("game_active_out", {11'b0, game_active_out}, {11'b0, exp_game});
      applyStimulus();
    end
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0;
    hblnk_in = 0; vblnk_in = 0; hsync_in = 0; vsync_in = 0;
    rgb_map_in = 12'hF00; rgb_menu_in = 12'h0F0;
    start_in = 0; esc_in = 0;
    run_cycles(3);
    rst = 1'b0;

    $display("[TB] idle in menu");
    run_cycles(2 * FRAME_LEN);

    $display("[TB] start pulse, esc presses while fading");
    start_mode = 3;
    run_cycles(20 * FRAME_LEN);
    esc_mode = 2;
    run_cycles(8 * FRAME_LEN);
    esc_mode = 0;
    run_cycles(8 * FRAME_LEN);

    $display("[TB] esc pulse back to menu");
    esc_mode = 3;
    run_cycles(36 * FRAME_LEN);

    $display("[TB] start and esc held together");
    start_mode = 1;
    esc_mode   = 1;
    run_cycles(36 * FRAME_LEN);
    start_mode = 0;
    esc_mode   = 0;
    run_cycles(2 * FRAME_LEN);
    esc_mode = 3;
    run_cycles(36 * FRAME_LEN);

    $display("[TB] reset in the middle of a transition");
    start_mode = 3;
    run_cycles(11 * FRAME_LEN + 3);
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    run_cycles(3 * FRAME_LEN);

    $display("[TB] random presses");
    start_mode = 2;
    esc_mode   = 2;
    run_cycles(120 * FRAME_LEN);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/screen_mux.md
SCREEN_MUX -- requirements
Module: screen_mux

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 2: frames spent at each fade level (1..15).
REQ-002 clk  input  1  pixel clock; all logic in this single domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 hcount_in, vcount_in  input  11/10  pixel position from the gui stage.
REQ-005 hblnk_in, vblnk_in, hsync_in, vsync_in  input  1 each  timing from the gui stage.
REQ-006 rgb_map_in, rgb_menu_in  input  12 each  map and menu pixels, aligned with the timing inputs.
REQ-007 start_in  input  1  synchronous level: menu "play" request.
REQ-008 esc_in  input  1  synchronous level: return-to-menu request.
REQ-009 hsync_out, vsync_out  output  1 each  sync delayed by one clk.
REQ-010 rgb_out  output  12  final pixel, 4:4:4 RGB.
REQ-011 game_active_out  output  1  high only in state GAME.

Function
REQ-012 Latency: exactly 1 clk from inputs to hsync_out, vsync_out and rgb_out; all outputs registered.
REQ-013 frame_tick: single-cycle pulse on each rising edge of vblnk_in (registered previous value).
REQ-014 start_in and esc_in: rising-edge detected internally; levels held high cause one event only.
REQ-015 States: MENU, FADE_OUT, FADE_IN, GAME; register dest (0 = menu, 1 = game).
REQ-016 MENU: start edge -> FADE_OUT, dest = 1; esc ignored.
REQ-017 GAME: esc edge -> FADE_OUT, dest = 0; start ignored.
REQ-018 FADE_OUT: source = previous screen (not dest); when level reaches 0 -> FADE_IN, source switches to dest.
REQ-019 FADE_IN: source = dest; when level reaches 16 -> GAME if dest = 1, else MENU.
REQ-020 All start and esc edges during FADE_OUT/FADE_IN are discarded, not queued.
REQ-021 Level: 5-bit, 0..16; 16 in MENU/GAME; on frame_tick, step counter increments; at FRAMES_PER_STEP the counter clears and level moves by 1 (down in FADE_OUT, up in FADE_IN), saturating at 0/16.
REQ-022 Full transition: 32 * FRAMES_PER_STEP frames.
REQ-023 Channel scaling: out = (ch * level) >> 4, 4-bit channel x 5-bit level, 9-bit product, truncated; level 16 is identity, level 0 is black.
REQ-024 rgb_out = 12'h000 whenever hblnk_in or vblnk_in is high (sampled at the input cycle).
REQ-025 State, level and source change only on frame_tick (except edge capture), so no frame shows a mid-frame switch.
REQ-026 Edge seen in MENU/GAME: state changes immediately; first level step happens on following frame_ticks.

Reset
REQ-027 Reset values: state MENU, dest 0, level 16, step counter 0, edge registers 0.
REQ-028 Reset values: rgb_out 0, hsync_out 0, vsync_out 0, game_active_out 0.
REQ-029 Reset asserted mid-fade: block returns to MENU at full brightness; no residual dest.

Configuration
REQ-030 Macro SCREEN_FADE_EN defined: fade behaviour as in REQ-018..REQ-023.
REQ-031 Macro SCREEN_FADE_EN undefined: FADE_IN, FADE_OUT, the level and step logic and the multipliers are removed.
REQ-032 Without SCREEN_FADE_EN: an accepted edge sets a pending flag; the next frame_tick switches directly MENU<->GAME; rgb is passed unscaled; latency stays 1 clk.

Structure
REQ-033 Shared package gui_pkg holds: state encoding, LEVEL_MAX = 16, RGB_W = 12, channel width 4.
REQ-034 One sub-module fade_scaler: combinational; 12-bit rgb and 5-bit level in, 12-bit scaled rgb out; instantiated once.

Verification
REQ-035 Reset, map = 12'hF00, menu = 12'h0F0, active area -> rgb_out = 12'h0F0 one clk later; game_active_out = 0.
REQ-036 start pulse in MENU, FRAMES_PER_STEP = 1:
- menu channels step down 15,14,...; level 0 after 16 frames.
- map rises to 12'hF00 at frame 32; then game_active_out = 1.
REQ-037 start and esc held high together in MENU -> one transition to GAME only; esc is never acted on while held.
REQ-038 esc pulses during FADE_IN -> ignored; block ends in GAME; a later esc starts the return to menu.
REQ-039 hblnk_in = 1 with rgb inputs 12'hFFF -> rgb_out = 12'h000; hsync_out/vsync_out equal the inputs delayed 1 clk.
REQ-040 Reset asserted at level 5 of FADE_OUT -> immediate menu, level 16.
REQ-041 SCREEN_FADE_EN undefined: start -> switch at the next vblnk_in rise, no intermediate colours.
